// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the hazard controller and the pipeline / data-memory port.
// The master modport is the controller's view; slave is the pipeline's view.
interface pipeline_hazard_ctrl_if;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_ex_rd;
  logic        id_ex_mem_read;
  logic [4:0]  ex_mem_rd;
  logic        ex_mem_reg_write;
  logic        ex_mem_mem_read;
  logic        ex_mem_mem_access;
  logic        branch_taken;
  logic        dmem_ready;
  logic        dmem_req;
  logic        pc_stall;
  logic        if_id_stall;
  logic        id_ex_stall;
  logic        ex_mem_stall;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        mem_wb_bubble;
  logic        mem_ex_finish;
  logic        mem_mem_finish;
  logic        mem_timeout;
  logic [31:0] stall_cycles;

  modport master (
    input  id_rs1, id_rs2, id_ex_rd, id_ex_mem_read, ex_mem_rd, ex_mem_reg_write,
           ex_mem_mem_read, ex_mem_mem_access, branch_taken, dmem_ready,
    output dmem_req, pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush,
           id_ex_flush, mem_wb_bubble, mem_ex_finish, mem_mem_finish, mem_timeout,
           stall_cycles
  );

  modport slave (
    output id_rs1, id_rs2, id_ex_rd, id_ex_mem_read, ex_mem_rd, ex_mem_reg_write,
           ex_mem_mem_read, ex_mem_mem_access, branch_taken, dmem_ready,
    input  dmem_req, pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush,
           id_ex_flush, mem_wb_bubble, mem_ex_finish, mem_mem_finish, mem_timeout,
           stall_cycles
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer: load-use bubbles, multi-cycle data-memory waits, branch flushes,
// forwarding-valid qualifiers, a sticky memory timeout and a stall-cycle counter.
module pipeline_hazard_ctrl #(
  parameter int MAX_WAIT = 255,
  parameter int WAIT_W   = 8
) (
  input logic                   clk,
  input logic                   rst,
  pipeline_hazard_ctrl_if.master hz
);

  typedef enum logic {RUN, MEM_WAIT} state_e;

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                timeout_q, timeout_d;
  logic [31:0]         stall_cnt_q, stall_cnt_d;
  logic                lu;
  logic                mem_busy;
  logic                mem_stall;

  assign lu = hz.id_ex_mem_read && (hz.id_ex_rd != 5'd0) &&
              ((hz.id_ex_rd == hz.id_rs1) || (hz.id_ex_rd == hz.id_rs2));

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    state_d           = state_q;
    wait_cnt_d        = wait_cnt_q;
    timeout_d         = timeout_q;
    mem_busy          = 1'b0;
    mem_stall         = 1'b0;
    hz.dmem_req       = 1'b0;
    hz.pc_stall       = 1'b0;
    hz.if_id_stall    = 1'b0;
    hz.id_ex_stall    = 1'b0;
    hz.ex_mem_stall   = 1'b0;
    hz.if_id_flush    = 1'b0;
    hz.id_ex_flush    = 1'b0;
    hz.mem_wb_bubble  = 1'b0;
    hz.mem_ex_finish  = 1'b0;
    hz.mem_mem_finish = 1'b0;

    if (!rst) begin
      mem_busy    = (state_q == MEM_WAIT) || hz.ex_mem_mem_access;
      mem_stall   = mem_busy && !hz.dmem_ready;
      hz.dmem_req = mem_busy;

      if (mem_stall) begin
        // Whole pipeline frozen; branch and load-use wait until the access completes.
        state_d          = MEM_WAIT;
        hz.pc_stall      = 1'b1;
        hz.if_id_stall   = 1'b1;
        hz.id_ex_stall   = 1'b1;
        hz.ex_mem_stall  = 1'b1;
        hz.mem_wb_bubble = 1'b1;
        wait_cnt_d = (wait_cnt_q == {WAIT_W{1'b1}}) ? wait_cnt_q : wait_cnt_q + 1'b1;
        if (wait_cnt_d == WAIT_W'(MAX_WAIT)) timeout_d = 1'b1;
      end else begin
        state_d    = RUN;
        wait_cnt_d = '0;
        if (hz.branch_taken) begin
          hz.if_id_flush = 1'b1;
          hz.id_ex_flush = 1'b1;
        end else if (lu) begin
          hz.pc_stall    = 1'b1;
          hz.if_id_stall = 1'b1;
          hz.id_ex_flush = 1'b1;
        end
      end

      hz.mem_ex_finish  = hz.ex_mem_reg_write && !hz.ex_mem_mem_read;
      hz.mem_mem_finish = hz.ex_mem_mem_read && hz.dmem_req && hz.dmem_ready;
    end

    stall_cnt_d = stall_cnt_q + {31'd0, hz.pc_stall};
  end

  assign hz.mem_timeout  = timeout_q && !rst;
  assign hz.stall_cycles = stall_cnt_q;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
